// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multi-cycle multiply/divide/modulo unit:
// op_sel values, sequencer states and the ControlWord bits the EX glue decodes.
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIV  = 2'b10,
    OP_MOD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIN  = 2'b11
  } state_e;

  // ControlWord bit positions used to build start/op_sel in EX
  localparam int CW_IS_DIV = 6;
  localparam int CW_IS_MOD = 5;
  localparam int CW_IS_MUL = 3;

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: one shift-add multiply step or one restoring-divide step
// per enabled cycle. Outputs are the post-step values so the sequencer can
// register the final result on the same edge as the last step.
module muldiv_iter_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
  logic [WIDTH-1:0] acc_d, quo_d, rem_d;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;

  always_comb begin
    acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, dvs_q};
    // rem_shift < 2*divisor, so the difference always fits in WIDTH bits
    rem_d     = rem_ge ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
    // The dividend register doubles as the quotient: bits shift in at the LSB
    quo_d     = {dvd_q[WIDTH-2:0], rem_ge};
  end

  assign prod_o = acc_d;
  assign quo_o  = quo_d;
  assign rem_o  = rem_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      dvd_q    <= a_i;
      dvs_q    <= b_i;
      rem_q    <= '0;
    end else if (step_i && !div_mode_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end else if (step_i && div_mode_i) begin
      rem_q    <= rem_d;
      dvd_q    <= quo_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage multi-cycle mul/div/mod sequencer: FSM, iteration counter,
// front-end stall, done pulse and divide-by-zero bypass around muldiv_iter_dp.
module ex_muldiv_seq
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mod_q, done_q, dz_q;
  logic [WIDTH-1:0] result_q;
  logic             accept, step, last_step;
  logic [WIDTH-1:0] prod_d, quo_d, rem_d;

  assign accept    = (state_q == IDLE) && start && (op_sel != OP_NONE) && !flush;
  assign step      = ((state_q == MUL) || (state_q == DIV)) && !flush;
  assign last_step = (cnt_q == CNT_W'(1));
  assign stall     = accept || step;

  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = dz_q;

  muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (accept),
    .step_i     (step),
    .div_mode_i (state_q == DIV),
    .a_i        (a),
    .b_i        (b),
    .prod_o     (prod_d),
    .quo_o      (quo_d),
    .rem_o      (rem_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mod_q    <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q <= CNT_W'(WIDTH);
            mod_q <= (op_sel == OP_MOD);
            if (op_sel == OP_MUL) begin
              state_q <= MUL;
            end else if (b == '0) begin
              // Divide by zero skips iteration entirely
              state_q  <= FIN;
              done_q   <= 1'b1;
              dz_q     <= 1'b1;
              result_q <= (op_sel == OP_DIV) ? '1 : a;
            end else begin
              state_q <= DIV;
            end
          end
        end
        MUL, DIV: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_step) begin
              state_q  <= FIN;
              done_q   <= 1'b1;
              dz_q     <= 1'b0;
              result_q <= (state_q == MUL) ? prod_d : (mod_q ? rem_d : quo_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Randomized self-checking bench for ex_muldiv_seq against a plain-arithmetic
// reference of multiply low word, quotient and remainder with their latencies.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op_sel;
  logic [31:0] a, b;
  logic        flush;
  logic        stall, done, div_zero;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;
  int cyc_g = 0;
  int done_at = 0;

  ex_muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_sel   (op_sel),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .stall    (stall),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    longint unsigned p;
    if (op == 2'b01) begin
      p = longint'(x) * longint'(y);
      return p[31:0];
    end
    if (y == 0) return (op == 2'b10) ? 32'hFFFF_FFFF : x;
    return (op == 2'b10) ? (x / y) : (x % y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation with start held until done, then leave the unit in IDLE
  task automatic run_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    int          cyc;
    int          lat;
    bit          seen;
    bit          stall_ok;
    logic [31:0] r;
    logic        dz;
    logic [31:0] exp_r;
    int          exp_lat;
    exp_r   = ref_result(op, av, bv);
    exp_lat = (op != 2'b01 && bv == 0) ? 1 : 33;
    op_sel = op; a = av; b = bv; start = 1'b1; flush = 1'b0;
    #1;
    chk("stall_accept", {31'd0, stall}, 32'd1);
    cyc = 0; lat = -1; seen = 0; stall_ok = 1; r = '0; dz = 1'b0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (done) begin
        seen = 1; lat = cyc; r = result; dz = div_zero;
        chk("stall_fin", {31'd0, stall}, 32'd0);
      end else if (!stall) begin
        stall_ok = 0;
      end
    end
    done_at = cyc_g;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", r, exp_r);
    chk("div_zero", {31'd0, dz}, {31'd0, (op != 2'b01 && bv == 0)});
    chk("stall_run", {31'd0, stall_ok}, 32'd1);
    start = 1'b0;
    tick();
    chk("idle_after", {30'd0, stall, done}, 32'd0);
    chk("result_hold", result, exp_r);
  endtask

  initial begin
    int t0;
    int ndone;
    rst = 1'b1; start = 1'b0; op_sel = 2'b00; a = '0; b = '0; flush = 1'b0;
    tick(); tick();
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    tick();

    run_op(2'b01, 32'd7, 32'd6);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2);
    run_op(2'b10, 32'd100, 32'd7);
    t0 = done_at;
    run_op(2'b11, 32'd100, 32'd7);
    chk("b2b_gap", 32'(done_at - t0), 32'd34);
    run_op(2'b10, 32'd55, 32'd0);
    run_op(2'b11, 32'd55, 32'd0);

    // Flush a divide mid-iteration
    op_sel = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1; flush = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    flush = 1'b1; start = 1'b0;
    #1;
    chk("stall_flush", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("flush_nodone", 32'(ndone), 32'd0);
    run_op(2'b01, 32'd3, 32'd3);

    // Reset in the middle of a multiply
    op_sel = 2'b01; a = 32'd123; b = 32'd456; start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; start = 1'b0;
    tick();
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    rst = 1'b0;
    tick();

    // Illegal op_sel is ignored
    op_sel = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    #1;
    chk("op00_stall", {31'd0, stall}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || stall) ndone++;
    end
    chk("op00_quiet", 32'(ndone), 32'd0);
    start = 1'b0;
    tick();

    for (int k = 0; k < 16; k++) begin
      logic [1:0]  op;
      logic [31:0] av, bv;
      int          mode;
      op   = 2'($urandom_range(1, 3));
      av   = $urandom;
      mode = $urandom_range(0, 3);
      if (mode == 0)      bv = 32'd0;
      else if (mode == 1) bv = 32'($urandom_range(1, 15));
      else                bv = $urandom;
      run_op(op, av, bv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
